spi_reg_bank: RTL and testbench



---
 rtl/spi_reg_pkg.sv | 27 ++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_reg_bank.sv | 185 ++++++++++++++++++
 tb/tb_spi_reg_bank.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types, constants and frame-geometry helpers for the SPI register bank.
// Frames are MSB first: R/W bit, then address, then data in the low bits.
package spi_reg_pkg;

    localparam int   DEF_SYNC_STAGES = 2;
    localparam logic RW_WRITE        = 1'b1;
    localparam int   DATA_LSB        = 0;

    typedef enum logic [1:0] {
        ST_UNARMED,
        ST_IDLE,
        ST_FRAME
    } rx_state_t;

    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    function automatic int addr_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int rw_pos(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with one-clk rise/fall
// pulses taken from the last two synchronised samples.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stages;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= {SYNC_STAGES{RESET_VAL}};
            prev   <= RESET_VAL;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
            prev   <= stages[SYNC_STAGES-1];
        end
    end

    assign level = stages[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_reg_bank.sv
// Parametrised SPI (mode 0) register bank with read-back over cipo and a
// sticky malformed-frame flag; all decoding happens in the clk domain.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       ncs,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]        wr_strobe,
    output logic                       frame_err
);

    localparam int FRAME_W  = frame_w(ADDR_W, DATA_W);
    localparam int RW_POS   = rw_pos(ADDR_W, DATA_W);
    localparam int ADDR_LSB = addr_lsb(DATA_W);
    localparam int CNT_W    = $clog2(FRAME_W + 2);
    localparam int WARM_W   = $clog2(SYNC_STAGES + 1);

    logic                   sclk_level_unused, sclk_rise, sclk_fall;
    logic                   ncs_level, ncs_rise, ncs_fall;
    logic [SYNC_STAGES-1:0] copi_sync;
    logic                   copi_s;

    rx_state_t              state, state_next;
    logic [WARM_W-1:0]      warm;
    logic                   warm_done;

    logic [FRAME_W-1:0]     shift_reg, next_shift;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-1:0]      tx;
    logic [DATA_W-1:0]      regs [NUM_REGS];
    logic [DATA_W-1:0]      rd_data;
    logic [ADDR_W-1:0]      rd_addr, cm_addr, pend_addr;
    logic [DATA_W-1:0]      cm_data, pend_data;
    logic                   cm_rw, cm_addr_ok, pend_wr;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sclk),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ncs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ncs),
        .level (ncs_level),
        .rise  (ncs_rise),
        .fall  (ncs_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            copi_sync <= '0;
        end else begin
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
        end
    end

    assign copi_s = copi_sync[SYNC_STAGES-1];

    // The synchronised ncs level is only trustworthy once the reset value has
    // drained out of the chain; a select held low through reset never arms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm  <= '0;
            state <= ST_UNARMED;
        end else begin
            if (!warm_done) begin
                warm <= warm + 1'b1;
            end
            state <= state_next;
        end
    end

    assign warm_done = (warm == WARM_W'(SYNC_STAGES));

    always_comb begin
        state_next = state;
        case (state)
            ST_UNARMED: if (warm_done && ncs_level) state_next = ST_IDLE;
            ST_IDLE:    if (ncs_fall)               state_next = ST_FRAME;
            ST_FRAME:   if (ncs_rise)               state_next = ST_IDLE;
            default:                                state_next = ST_UNARMED;
        endcase
    end

    always_comb begin
        next_shift = {shift_reg[FRAME_W-2:0], copi_s};
        rd_addr    = next_shift[ADDR_W-1:0];
        rd_data    = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_addr == ADDR_W'(k)) begin
                rd_data = regs[k];
            end
        end
    end

    assign cm_rw      = shift_reg[RW_POS];
    assign cm_addr    = shift_reg[ADDR_LSB +: ADDR_W];
    assign cm_data    = shift_reg[DATA_LSB +: DATA_W];
    assign cm_addr_ok = ({1'b0, cm_addr} < (ADDR_W + 1)'(NUM_REGS));

    // Frame receive, read-data shift-out and end-of-frame commit. A write is
    // staged for one clk so the register and its strobe change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            tx        <= '0;
            cipo      <= 1'b0;
            cipo_oe   <= 1'b0;
            frame_err <= 1'b0;
            pend_wr   <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
            wr_strobe <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else begin
            wr_strobe <= '0;
            pend_wr   <= 1'b0;
            if (pend_wr) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (pend_addr == ADDR_W'(k)) begin
                        regs[k]      <= pend_data;
                        wr_strobe[k] <= 1'b1;
                    end
                end
            end
            if (state == ST_FRAME) begin
                if (ncs_rise) begin
                    if (bit_cnt == CNT_W'(FRAME_W)) begin
                        if (cm_rw == RW_WRITE && cm_addr_ok) begin
                            pend_wr   <= 1'b1;
                            pend_addr <= cm_addr;
                            pend_data <= cm_data;
                        end
                    end else if (bit_cnt != '0) begin
                        frame_err <= 1'b1;
                    end
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                    tx        <= '0;
                    cipo      <= 1'b0;
                    cipo_oe   <= 1'b0;
                end else begin
                    if (sclk_rise) begin
                        shift_reg <= next_shift;
                        if (bit_cnt != CNT_W'(FRAME_W + 1)) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (bit_cnt == CNT_W'(ADDR_W) && next_shift[ADDR_W] != RW_WRITE) begin
                            tx      <= rd_data;
                            cipo_oe <= 1'b1;
                        end
                    end
                    if (sclk_fall && cipo_oe) begin
                        cipo <= tx[DATA_W-1];
                        tx   <= {tx[DATA_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign reg_q[k*DATA_W +: DATA_W] = regs[k];
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: drives mode-0 SPI frames and checks
// register contents, write strobes, read-back data and the frame error flag.
module tb_spi_reg_bank;

    localparam int NUM_REGS = 5;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 7;
    localparam int HALF     = 80;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       sclk;
    logic                       ncs;
    logic                       copi;
    logic                       cipo;
    logic                       cipo_oe;
    logic [NUM_REGS*DATA_W-1:0] reg_q;
    logic [NUM_REGS-1:0]        wr_strobe;
    logic                       frame_err;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [NUM_REGS-1:0]        strobe;
        logic [NUM_REGS*DATA_W-1:0] regs;
    } wr_exp_t;

    wr_exp_t           wr_q[$];
    logic [DATA_W-1:0] rd_q[$];
    logic [DATA_W-1:0] model [NUM_REGS];

    logic [DATA_W-1:0]   rx_byte;
    bit                  oe_seen;
    logic [NUM_REGS-1:0] got_strobe;
    int                  strobe_cycles;

    always #5 clk = ~clk;

    spi_reg_bank #(
        .NUM_REGS    (NUM_REGS),
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .ncs       (ncs),
        .copi      (copi),
        .cipo      (cipo),
        .cipo_oe   (cipo_oe),
        .reg_q     (reg_q),
        .wr_strobe (wr_strobe),
        .frame_err (frame_err)
    );

    function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
        logic [NUM_REGS*DATA_W-1:0] f;
        for (int k = 0; k < NUM_REGS; k++) begin
            f[k*DATA_W +: DATA_W] = model[k];
        end
        return f;
    endfunction

    // Lower ncs and clock out nbits (first bit = bits[nbits-1]); cipo is
    // captured just before each rise that falls in the data field.
    task automatic spi_bits(input logic [16:0] bits, input int nbits);
        rx_byte = '0;
        oe_seen = 1'b0;
        ncs     = 1'b0;
        #HALF;
        for (int i = 0; i < nbits; i++) begin
            copi = bits[nbits-1-i];
            #HALF;
            if (i >= 1 + ADDR_W && i < 1 + ADDR_W + DATA_W) begin
                rx_byte = {rx_byte[DATA_W-2:0], cipo};
            end
            if (cipo_oe) oe_seen = 1'b1;
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
    endtask

    // Raise ncs, then watch a bounded window for write strobes.
    task automatic spi_end_and_watch();
        #HALF;
        if (cipo_oe) oe_seen = 1'b1;
        ncs           = 1'b1;
        got_strobe    = '0;
        strobe_cycles = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (wr_strobe != '0) begin
                got_strobe    = got_strobe | wr_strobe;
                strobe_cycles = strobe_cycles + 1;
            end
        end
    endtask

    task automatic run_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        logic [NUM_REGS-1:0] s;
        s = '0;
        if (addr < NUM_REGS) begin
            model[addr] = data;
            s[addr]     = 1'b1;
        end
        wr_q.push_back('{strobe: s, regs: model_flat()});
        spi_bits({1'b1, addr, data}, 16);
        spi_end_and_watch();
    endtask

    task automatic run_read(input logic [ADDR_W-1:0] addr);
        rd_q.push_back((addr < NUM_REGS) ? model[addr] : '0);
        spi_bits({1'b0, addr, 8'h00}, 16);
        spi_end_and_watch();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ncs   = 1'b1;
        sclk  = 1'b0;
        copi  = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (reg_q !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_reg_q: got %h expected 0", reg_q);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (wr_strobe !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_wr_strobe: got %b expected 0", wr_strobe);
        end
        tests_run++;
        if (frame_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err);
        end
        tests_run++;
        if (cipo !== 1'b0 || cipo_oe !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_cipo: got cipo=%b oe=%b expected 0/0", cipo, cipo_oe);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_write_addr0();
        wr_exp_t e;
        run_write(7'd0, 8'hF0);
        e = wr_q.pop_front();
        tests_run++;
        if (got_strobe !== e.strobe || strobe_cycles != 1) begin
            tests_failed++;
            $display("[TB] FAIL wr0_strobe: got %b x%0d expected %b x1", got_strobe, strobe_cycles, e.strobe);
        end
        tests_run++;
        if (reg_q !== e.regs) begin
            tests_failed++;
            $display("[TB] FAIL wr0_reg_q: got %h expected %h", reg_q, e.regs);
        end
        tests_run++;
        if (frame_err !== 1'b0 || oe_seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL wr0_err_oe: got err=%b oe=%b expected 0/0", frame_err, oe_seen);
        end
    endtask

    task automatic test_read_back();
        wr_exp_t           e;
        logic [DATA_W-1:0] r;
        run_write(7'd4, 8'h80);
        e = wr_q.pop_front();
        tests_run++;
        if (got_strobe !== e.strobe || strobe_cycles != 1 || reg_q !== e.regs) begin
            tests_failed++;
            $display("[TB] FAIL wr4: got strobe=%b x%0d q=%h expected %b x1 q=%h",
                     got_strobe, strobe_cycles, reg_q, e.strobe, e.regs);
        end
        run_read(7'd4);
        r = rd_q.pop_front();
        tests_run++;
        if (rx_byte !== r) begin
            tests_failed++;
            $display("[TB] FAIL rd4_data: got %h expected %h", rx_byte, r);
        end
        tests_run++;
        if (oe_seen !== 1'b1 || cipo_oe !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rd4_oe: got during=%b after=%b expected 1/0", oe_seen, cipo_oe);
        end
        run_read(7'd0);
        r = rd_q.pop_front();
        tests_run++;
        if (rx_byte !== r) begin
            tests_failed++;
            $display("[TB] FAIL rd0_data: got %h expected %h", rx_byte, r);
        end
    endtask

    task automatic test_out_of_range();
        wr_exp_t           e;
        logic [DATA_W-1:0] r;
        run_write(7'd5, 8'hAA);
        e = wr_q.pop_front();
        tests_run++;
        if (got_strobe !== e.strobe || strobe_cycles != 0 || reg_q !== e.regs) begin
            tests_failed++;
            $display("[TB] FAIL oor_write: got strobe=%b x%0d q=%h expected %b x0 q=%h",
                     got_strobe, strobe_cycles, reg_q, e.strobe, e.regs);
        end
        run_read(7'd5);
        r = rd_q.pop_front();
        tests_run++;
        if (rx_byte !== r || frame_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL oor_read: got %h err=%b expected %h err=0", rx_byte, frame_err, r);
        end
    endtask

    task automatic test_short_frame();
        wr_exp_t e;
        spi_bits(17'b1000001101, 10);
        spi_end_and_watch();
        tests_run++;
        if (reg_q !== model_flat() || strobe_cycles != 0) begin
            tests_failed++;
            $display("[TB] FAIL short_nowrite: got q=%h strobes=%0d expected q=%h strobes=0",
                     reg_q, strobe_cycles, model_flat());
        end
        tests_run++;
        if (frame_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL short_err: got %b expected 1", frame_err);
        end
        run_write(7'd3, 8'h5A);
        e = wr_q.pop_front();
        tests_run++;
        if (got_strobe !== e.strobe || reg_q !== e.regs || frame_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL short_after: got strobe=%b q=%h err=%b expected %b q=%h err=1",
                     got_strobe, reg_q, frame_err, e.strobe, e.regs);
        end
    endtask

    task automatic test_long_frame();
        wr_exp_t e;
        spi_bits(17'b1_0000001_01010101_1, 17);
        spi_end_and_watch();
        tests_run++;
        if (reg_q !== model_flat() || strobe_cycles != 0 || frame_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL long_frame: got q=%h strobes=%0d err=%b expected q=%h strobes=0 err=1",
                     reg_q, strobe_cycles, frame_err, model_flat());
        end
        run_write(7'd1, 8'h99);
        e = wr_q.pop_front();
        tests_run++;
        if (got_strobe !== e.strobe || reg_q !== e.regs) begin
            tests_failed++;
            $display("[TB] FAIL long_after: got strobe=%b q=%h expected %b q=%h",
                     got_strobe, reg_q, e.strobe, e.regs);
        end
    endtask

    task automatic test_reset_mid_frame();
        wr_exp_t e;
        spi_bits(17'({1'b1, 7'd2, 8'h3C} >> 7), 9);
        rst_n = 1'b0;
        #100;
        ncs  = 1'b1;
        sclk = 1'b0;
        #100;
        rst_n = 1'b1;
        for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
        repeat (10) @(negedge clk);
        tests_run++;
        if (reg_q !== '0 || frame_err !== 1'b0 || wr_strobe !== '0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_state: got q=%h err=%b strobe=%b expected 0/0/0",
                     reg_q, frame_err, wr_strobe);
        end
        run_write(7'd2, 8'h3C);
        e = wr_q.pop_front();
        tests_run++;
        if (got_strobe !== e.strobe || strobe_cycles != 1 || reg_q !== e.regs) begin
            tests_failed++;
            $display("[TB] FAIL midrst_write: got strobe=%b x%0d q=%h expected %b x1 q=%h",
                     got_strobe, strobe_cycles, reg_q, e.strobe, e.regs);
        end
    endtask

    task automatic test_back_to_back();
        wr_exp_t           e;
        logic [DATA_W-1:0] r;
        for (int k = 0; k < NUM_REGS; k++) begin
            run_write(ADDR_W'(k), DATA_W'($urandom_range(0, 255)));
            e = wr_q.pop_front();
            tests_run++;
            if (got_strobe !== e.strobe || strobe_cycles != 1 || reg_q !== e.regs) begin
                tests_failed++;
                $display("[TB] FAIL b2b_write%0d: got strobe=%b x%0d q=%h expected %b x1 q=%h",
                         k, got_strobe, strobe_cycles, reg_q, e.strobe, e.regs);
            end
        end
        for (int k = NUM_REGS - 1; k >= 0; k--) begin
            run_read(ADDR_W'(k));
            r = rd_q.pop_front();
            tests_run++;
            if (rx_byte !== r) begin
                tests_failed++;
                $display("[TB] FAIL b2b_read%0d: got %h expected %h", k, rx_byte, r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_addr0();
        test_read_back();
        test_out_of_range();
        test_short_frame();
        test_long_frame();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
